two_ch_rr_mux_sel: RTL and testbench
====================================

Name: two_ch_rr_mux_sel

Overview:
- Upstream select/arbitration stage for the 4-bit 2:1 mux datapath.
- Takes two 4-bit producer channels with valid/ready handshakes and arbitrates between them round-robin, with a bounded burst length.
- Drives the mux select S. Captures the selected word in a single output register with a valid/ready handshake toward the consumer.
- Gives the combinational mux a cycle-accurate, back-pressured front end.

Parameters:
- BURST, 2, max consecutive transfers granted to one channel while the other channel is requesting (legal range 1..15).
- CNT_W, 4, width of the burst counter; must satisfy 2^CNT_W > BURST.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- ch0_valid  input  1  channel 0 has a word
- ch0_data  input  4  channel 0 word
- ch0_ready  output  1  channel 0 word accepted this cycle
- ch1_valid  input  1  channel 1 has a word
- ch1_data  input  4  channel 1 word
- ch1_ready  output  1  channel 1 word accepted this cycle
- sel  output  1  mux select S (0 = ch0, 1 = ch1)
- out_valid  output  1  output register holds a word
- out_data  output  4  registered selected word
- out_src  output  1  channel that produced out_data
- out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset: one clock, synchronous, active-high; rst high at a rising clk edge clears state.
  - out_valid=0, out_data=0, out_src=0.
  - last_grant=1, so ch0 wins first when both channels request.
  - burst_cnt=0, state=EMPTY.
  - rst overrides all other activity, including a transfer in the same cycle; any in-flight word is dropped.
- load = !out_valid || out_ready. This is a pipeline register with no bubble on continuous streaming.
- Grant (combinational, every cycle):
  - Only one channel valid: grant that channel.
  - Both valid, burst_cnt < BURST: grant last_grant (burst continues).
  - Both valid, burst_cnt == BURST: grant !last_grant.
  - Neither valid: grant = last_grant (sel holds steady).
- sel = grant.
- chN_ready = load && (grant == N) && chN_valid. Ready never asserts for a channel that is not valid, so at most one ready is high per cycle.
- Datapath: one 4-bit mux instance, select = sel, I0 = ch0_data, I1 = ch1_data.
- Accept event (chN_valid && chN_ready) at a clk edge:
  - out_data <= mux output, out_src <= grant, out_valid <= 1.
  - If grant == last_grant, burst_cnt <= burst_cnt + 1, saturating at BURST; otherwise burst_cnt <= 1.
  - last_grant <= grant.
- No accept, and out_valid && out_ready: out_valid <= 0; out_data and out_src hold their values.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k.
  - Throughput 1 word/cycle while out_ready=1.
- States:
  - EMPTY (out_valid=0): on accept, go to FULL.
  - FULL (out_valid=1): on accept, stay FULL (simultaneous drain and refill).
  - FULL: on out_ready without accept, go to EMPTY.
  - FULL: on !out_ready, hold; out_data, out_src and out_valid must stay stable, and chN_ready = 0.
- burst_cnt is only reset by rst or by a switch of channel.
  - An idle gap keeps burst_cnt and last_grant, so fairness persists across gaps.
- A channel dropping valid mid-burst lets the other channel win immediately; its burst count starts at 1.
- The output port is 4 bits wide with no width conversion; data is passed unmodified.

Decomposition:
- Shared package: constants SEL_CH0=1'b0, SEL_CH1=1'b1, and state encodings ST_EMPTY=1'b0, ST_FULL=1'b1.
- Sub-module: the existing mux2to1_4bit (built from mux2to1), instantiated once for the data path.
- Arbitration and the output register stay in this module.

Test Plan:
- Reset priority: rst for 2 cycles, then ch0_valid=ch1_valid=1, ch0_data=4'hA, ch1_data=4'h5, out_ready=1 -> first output 4'hA with out_src=0; with BURST=2 the sequence is A, A, 5, 5, A, ... (two per channel).
- Single channel: only ch1_valid=1 with data 3,4,5,6, out_ready=1 -> out_data 3,4,5,6 on consecutive cycles; sel=1 throughout; ch0_ready=0.
- Back-pressure: FULL with out_data=4'h7, out_ready=0 for 3 cycles while both channels are valid -> out_data stays 7, ch0_ready=ch1_ready=0; out_ready=1 -> 7 consumed and the next word loaded in the same cycle.
- Drain: a single word 4'hC, then no valids, out_ready=1 -> out_valid goes 1 for one cycle then 0; out_data stays 4'hC.
- Mid-burst drop: ch0 wins one word, ch0_valid falls, ch1 valid -> ch1 granted next cycle with burst_cnt=1; ch0 re-asserting valid waits until ch1 completes BURST transfers.
- Reset mid-stream: rst asserted while FULL with out_ready=0 -> next cycle out_valid=0, ch0_ready follows the ch0-first priority, and the dropped word is not emitted.

Source files
------------

// File: rtl/two_ch_rr_mux_sel_pkg.sv
// rtl/two_ch_rr_mux_sel_pkg.sv - shared select constants and output-register state encoding
package two_ch_rr_mux_sel_pkg;

   localparam logic SEL_CH0 = 1'b0;
   localparam logic SEL_CH1 = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/mux2to1.sv
// rtl/mux2to1.sv - single-bit 2:1 multiplexer
module mux2to1 (
   input  logic i0,
   input  logic i1,
   input  logic s,
   output logic y
);

   // s=0 passes i0, s=1 passes i1
   always_comb begin
      y = s ? i1 : i0;
   end

endmodule

// File: rtl/mux2to1_4bit.sv
// rtl/mux2to1_4bit.sv - 4-bit 2:1 multiplexer built from single-bit muxes
module mux2to1_4bit (
   input  logic [3:0] i0,
   input  logic [3:0] i1,
   input  logic       s,
   output logic [3:0] y
);

   for (genvar b = 0; b < 4; b++) begin : g_bit
      mux2to1 u_mux (
         .i0 (i0[b]),
         .i1 (i1[b]),
         .s  (s),
         .y  (y[b])
      );
   end

endmodule

// File: rtl/two_ch_rr_mux_sel.sv
// rtl/two_ch_rr_mux_sel.sv - round-robin burst arbiter driving the 4-bit mux select and output register
module two_ch_rr_mux_sel
   import two_ch_rr_mux_sel_pkg::*;
#(
   parameter int BURST = 2,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ch0_valid,
   input  logic [3:0] ch0_data,
   output logic       ch0_ready,
   input  logic       ch1_valid,
   input  logic [3:0] ch1_data,
   output logic       ch1_ready,
   output logic       sel,
   output logic       out_valid,
   output logic [3:0] out_data,
   output logic       out_src,
   input  logic       out_ready
);

   localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   state_t           state;
   state_t           state_nxt;
   logic             last_grant;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             grant;
   logic             load;
   logic             accept;
   logic [3:0]       mux_y;

   assign out_valid = (state == ST_FULL);
   assign load      = !out_valid || out_ready;
   assign sel       = grant;
   assign ch0_ready = load && (grant == SEL_CH0) && ch0_valid;
   assign ch1_ready = load && (grant == SEL_CH1) && ch1_valid;
   assign accept    = ch0_ready || ch1_ready;

   mux2to1_4bit u_mux (
      .i0 (ch0_data),
      .i1 (ch1_data),
      .s  (sel),
      .y  (mux_y)
   );

   // Grant: a lone requester wins; with both requesting, the owner keeps the
   // channel until its burst is spent. A zero count means no burst is owned
   // yet (after reset), so the channel opposite last_grant goes first.
   always_comb begin
      grant = last_grant;
      if (ch0_valid && !ch1_valid) begin
         grant = SEL_CH0;
      end else if (!ch0_valid && ch1_valid) begin
         grant = SEL_CH1;
      end else if (ch0_valid && ch1_valid) begin
         if ((burst_cnt != CNT_ZERO) && (burst_cnt < BURST_C)) begin
            grant = last_grant;
         end else begin
            grant = ~last_grant;
         end
      end
   end

   // Burst count advances (saturating) while the same channel keeps winning, restarts at 1 on a switch
   always_comb begin
      cnt_nxt = burst_cnt;
      if (grant == last_grant) begin
         if (burst_cnt < BURST_C) begin
            cnt_nxt = burst_cnt + CNT_ONE;
         end
      end else begin
         cnt_nxt = CNT_ONE;
      end
   end

   // Output register occupancy: fill on accept, empty on drain without refill
   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (accept) begin
               state_nxt = ST_FULL;
            end else if (out_ready) begin
               state_nxt = ST_EMPTY;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // State register, output word and arbitration history; reset drops any in-flight word
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_EMPTY;
         out_data   <= 4'h0;
         out_src    <= SEL_CH0;
         last_grant <= SEL_CH1;
         burst_cnt  <= CNT_ZERO;
      end else begin
         state <= state_nxt;
         if (accept) begin
            out_data   <= mux_y;
            out_src    <= grant;
            last_grant <= grant;
            burst_cnt  <= cnt_nxt;
         end
      end
   end

endmodule

// File: tb/tb_two_ch_rr_mux_sel.sv
// tb/tb_two_ch_rr_mux_sel.sv - directed self-checking bench for two_ch_rr_mux_sel
module tb_two_ch_rr_mux_sel;

   logic       clk = 1'b0;
   logic       rst;
   logic       ch0_valid;
   logic [3:0] ch0_data;
   logic       ch0_ready;
   logic       ch1_valid;
   logic [3:0] ch1_data;
   logic       ch1_ready;
   logic       sel;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_src;
   logic       out_ready;

   int total = 0;
   int bad = 0;

   two_ch_rr_mux_sel #(.BURST(2), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .ch0_valid (ch0_valid),
      .ch0_data  (ch0_data),
      .ch0_ready (ch0_ready),
      .ch1_valid (ch1_valid),
      .ch1_data  (ch1_data),
      .ch1_ready (ch1_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      ch0_valid = 1'b0; ch1_valid = 1'b0;
      ch0_data = 4'h0; ch1_data = 4'h0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++;
      if (out_data !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
      total++;
      if (out_src !== 1'b0) begin bad++; $display("FAIL reset_src got=%b exp=0", out_src); end
   endtask

   task automatic test_priority();
      logic [3:0] exp_d [6] = '{4'hA, 4'hA, 4'h5, 4'h5, 4'hA, 4'hA};
      logic       exp_s [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      rst = 1'b0;
      ch0_valid = 1'b1; ch0_data = 4'hA;
      ch1_valid = 1'b1; ch1_data = 4'h5;
      out_ready = 1'b1;
      #1;
      total++;
      if (ch0_ready !== 1'b1 || ch1_ready !== 1'b0) begin
         bad++; $display("FAIL prio_first_ready got=%b%b exp=10", ch0_ready, ch1_ready);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_src !== exp_s[i]) begin
            bad++;
            $display("FAIL prio_seq[%0d] got v=%b d=%h s=%b exp v=1 d=%h s=%b",
                     i, out_valid, out_data, out_src, exp_d[i], exp_s[i]);
         end
      end
      ch0_valid = 1'b0; ch1_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_channel();
      for (int i = 0; i < 4; i++) begin
         ch1_valid = 1'b1;
         ch1_data = 4'(3 + i);
         #1;
         total++;
         if (sel !== 1'b1 || ch0_ready !== 1'b0 || ch1_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_comb[%0d] got sel=%b r0=%b r1=%b exp sel=1 r0=0 r1=1",
                     i, sel, ch0_ready, ch1_ready);
         end
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_data !== 4'(3 + i) || out_src !== 1'b1) begin
            bad++;
            $display("FAIL single_out[%0d] got v=%b d=%h s=%b exp v=1 d=%h s=1",
                     i, out_valid, out_data, out_src, 4'(3 + i));
         end
      end
      ch1_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_pressure();
      ch0_valid = 1'b1; ch0_data = 4'h7;
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'h7) begin
         bad++; $display("FAIL bp_fill got v=%b d=%h exp v=1 d=7", out_valid, out_data);
      end
      out_ready = 1'b0;
      ch0_data = 4'h8;
      ch1_valid = 1'b1; ch1_data = 4'h9;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (ch0_ready !== 1'b0 || ch1_ready !== 1'b0) begin
            bad++; $display("FAIL bp_ready[%0d] got=%b%b exp=00", i, ch0_ready, ch1_ready);
         end
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_data !== 4'h7 || out_src !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d] got v=%b d=%h s=%b exp v=1 d=7 s=0",
                     i, out_valid, out_data, out_src);
         end
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (ch0_ready !== 1'b1 || ch1_ready !== 1'b0) begin
         bad++; $display("FAIL bp_release_ready got=%b%b exp=10", ch0_ready, ch1_ready);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'h8 || out_src !== 1'b0) begin
         bad++;
         $display("FAIL bp_refill got v=%b d=%h s=%b exp v=1 d=8 s=0", out_valid, out_data, out_src);
      end
      ch0_valid = 1'b0; ch1_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got v=%b exp=0", out_valid); end
   endtask

   task automatic test_drain();
      ch0_valid = 1'b1; ch0_data = 4'hC;
      out_ready = 1'b1;
      @(negedge clk);
      ch0_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'hC) begin
         bad++; $display("FAIL drain_load got v=%b d=%h exp v=1 d=c", out_valid, out_data);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_data !== 4'hC) begin
         bad++; $display("FAIL drain_empty got v=%b d=%h exp v=0 d=c", out_valid, out_data);
      end
   endtask

   task automatic test_mid_burst_drop();
      logic [3:0] exp_d [4] = '{4'h1, 4'h2, 4'h4, 4'h3};
      logic       exp_s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      ch0_valid = 1'b1; ch0_data = 4'h1; ch1_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_data !== exp_d[0] || out_src !== exp_s[0]) begin
         bad++; $display("FAIL mid_out[0] got d=%h s=%b exp d=1 s=0", out_data, out_src);
      end
      ch0_valid = 1'b0;
      ch1_valid = 1'b1; ch1_data = 4'h2;
      #1;
      total++;
      if (sel !== 1'b1 || ch1_ready !== 1'b1) begin
         bad++; $display("FAIL mid_switch got sel=%b r1=%b exp sel=1 r1=1", sel, ch1_ready);
      end
      @(negedge clk);
      total++;
      if (out_data !== exp_d[1] || out_src !== exp_s[1]) begin
         bad++; $display("FAIL mid_out[1] got d=%h s=%b exp d=2 s=1", out_data, out_src);
      end
      ch0_valid = 1'b1; ch0_data = 4'h3;
      ch1_data = 4'h4;
      #1;
      total++;
      if (ch0_ready !== 1'b0 || ch1_ready !== 1'b1) begin
         bad++; $display("FAIL mid_wait_ready got=%b%b exp=01", ch0_ready, ch1_ready);
      end
      @(negedge clk);
      total++;
      if (out_data !== exp_d[2] || out_src !== exp_s[2]) begin
         bad++; $display("FAIL mid_out[2] got d=%h s=%b exp d=4 s=1", out_data, out_src);
      end
      #1;
      total++;
      if (ch0_ready !== 1'b1 || ch1_ready !== 1'b0) begin
         bad++; $display("FAIL mid_turn_ready got=%b%b exp=10", ch0_ready, ch1_ready);
      end
      @(negedge clk);
      total++;
      if (out_data !== exp_d[3] || out_src !== exp_s[3]) begin
         bad++; $display("FAIL mid_out[3] got d=%h s=%b exp d=3 s=0", out_data, out_src);
      end
   endtask

   task automatic test_reset_mid_stream();
      out_ready = 1'b0;
      ch0_valid = 1'b1; ch0_data = 4'hE;
      ch1_valid = 1'b1; ch1_data = 4'hF;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'h3) begin
         bad++; $display("FAIL rstmid_full got v=%b d=%h exp v=1 d=3", out_valid, out_data);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (out_valid !== 1'b0 || out_data !== 4'h0) begin
         bad++; $display("FAIL rstmid_drop got v=%b d=%h exp v=0 d=0", out_valid, out_data);
      end
      #1;
      total++;
      if (ch0_ready !== 1'b1 || ch1_ready !== 1'b0) begin
         bad++; $display("FAIL rstmid_ready got=%b%b exp=10", ch0_ready, ch1_ready);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'hE || out_src !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_next got v=%b d=%h s=%b exp v=1 d=e s=0", out_valid, out_data, out_src);
      end
      ch0_valid = 1'b0; ch1_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_priority();
      test_single_channel();
      test_back_pressure();
      test_drain();
      test_mid_burst_drop();
      test_reset_mid_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
